// File: rtl/uart_tx.sv
// uart_tx: 8-bit serial transmitter with an internal baud divider.
//
// Frame: one start bit (0), eight data bits LSB first, an optional even
// parity bit, and one stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
// The divider restarts when a byte is accepted, so bit periods line up
// with the start of each frame.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the data byte) is sent
//   between the last data bit and the stop bit, giving an 11-bit frame.
//   When undefined, the frame is 10 bits (8N1).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit, 2..65535 (868 = 115200 baud @ 100 MHz)
//
// Ports
//   clk      input   system clock, rising edge
//   reset    input   synchronous active-high reset
//   i_data   input   byte to send, captured only when a send is accepted
//   i_send   input   transmit request, level sampled
//   o_ready  output  high while idle and able to accept a byte
//   o_tx     output  serial line, idles high, driven from a register
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_send,
  output logic       o_ready,
  output logic       o_tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_baudCnt;
  logic [15:0] w_baudCntNext;
  logic [2:0]  r_bitIdx;
  logic [2:0]  w_bitIdxNext;
  logic [7:0]  r_shift;
  logic [7:0]  w_shiftNext;
  logic        r_tx;
  logic        w_txNext;
  logic        w_bitTick;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
  logic        w_parityNext;
`endif

  // The last count of the divider marks the end of the current bit period.
  assign w_bitTick = (r_baudCnt == LAST_CNT);

  assign o_ready = (r_state == IDLE);
  assign o_tx    = r_tx;

  // State register. Reset wins over everything, which also makes a send
  // presented on a reset edge get dropped and aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baudCnt <= 16'd0;
      r_bitIdx  <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudCntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_shift   <= w_shiftNext;
      r_tx      <= w_txNext;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parityNext;
`endif
    end
  end

  // Next-state logic. The serial line value is computed one cycle ahead
  // so that it comes straight out of r_tx on the edge the bit begins;
  // that is why each transition loads the level of the bit being entered.
  // The shift register always presents the current data bit in bit 0,
  // so the next data bit is read from bit 1 before shifting.
  always_comb begin
    w_stateNext   = r_state;
    w_baudCntNext = w_bitTick ? 16'd0 : (r_baudCnt + 16'd1);
    w_bitIdxNext  = r_bitIdx;
    w_shiftNext   = r_shift;
    w_txNext      = r_tx;
`ifdef UART_TX_PARITY_EN
    w_parityNext  = r_parity;
`endif

    unique case (r_state)
      IDLE: begin
        w_baudCntNext = 16'd0;
        w_txNext      = 1'b1;
        if (i_send) begin
          w_stateNext  = START;
          w_txNext     = 1'b0;
          w_shiftNext  = i_data;
          w_bitIdxNext = 3'd0;
`ifdef UART_TX_PARITY_EN
          w_parityNext = ^i_data;
`endif
        end
      end

      START: begin
        if (w_bitTick) begin
          w_stateNext = DATA;
          w_txNext    = r_shift[0];
        end
      end

      DATA: begin
        if (w_bitTick) begin
          if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_stateNext = PARITY;
            w_txNext    = r_parity;
`else
            w_stateNext = STOP;
            w_txNext    = 1'b1;
`endif
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_shiftNext  = {1'b0, r_shift[7:1]};
            w_txNext     = r_shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bitTick) begin
          w_stateNext = STOP;
          w_txNext    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (w_bitTick) begin
          w_stateNext = IDLE;
          w_txNext    = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_txNext    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
//
// A frame-level model predicts ready/tx every cycle from the inputs alone:
// it knows only that an accepted byte occupies the line for FB bit times
// and which level each bit time carries. Directed sequences pin the model
// and the DUT to hand-computed waveforms; a randomized section exercises
// pulses, held sends, data churn during frames and mid-frame resets.
// A second instance at CLKS_PER_BIT=868 checks the full-rate timing.
module tb_uart_tx;

  localparam int N = 4;
  localparam int NS = 868;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       tx;

  logic       sendSlow = 1'b0;
  logic [7:0] dataSlow = 8'h00;
  logic       readySlow;
  logic       txSlow;

  int checks = 0;
  int errors = 0;

  logic rec [0:127];
  logic rdy [0:127];
  logic mRec [0:127];

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (data),
    .i_send  (send),
    .o_ready (ready),
    .o_tx    (tx)
  );

  uart_tx #(.CLKS_PER_BIT(NS)) dutSlow (
    .clk     (clk),
    .reset   (reset),
    .i_data  (dataSlow),
    .i_send  (sendSlow),
    .o_ready (readySlow),
    .o_tx    (txSlow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    @(negedge clk);
    send = s;
    data = d;
  endtask

  // Frame-level reference model: line levels in time order.
  function automatic logic [10:0] buildFrame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  int         mLeft = 0;
  logic [10:0] mFrame = 11'h7FF;
  bit         mValid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mLeft  <= 0;
      mValid <= 1'b1;
    end else if (mLeft == 0 && send) begin
      mFrame <= buildFrame(data);
      mLeft  <= FB * N;
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
    end
  end

  function automatic logic modelTx();
    int idx;
    if (mLeft == 0) return 1'b1;
    idx = (FB * N - mLeft) / N;
    return mFrame[idx];
  endfunction

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("ready_vs_model", {31'b0, ready}, {31'b0, (mLeft == 0)});
      checkOutput("tx_vs_model", {31'b0, tx}, {31'b0, modelTx()});
    end
  end

  // Records DUT outputs and model tx for len consecutive negedges,
  // starting at the current one.
  task automatic capture(input int len);
    for (int i = 0; i < len; i++) begin
      rec[i]  = tx;
      rdy[i]  = ready;
      mRec[i] = modelTx();
      @(negedge clk);
    end
  endtask

  // One-cycle send; returns at the first negedge after the accepting edge.
  task automatic pulseSend(input logic [7:0] d);
    applyStimulus(1'b1, d);
    applyStimulus(1'b0, 8'h00);
  endtask

  function automatic logic [7:0] decodeByte(input int base);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = rec[base + (1 + j) * N + N / 2];
    return b;
  endfunction

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  int expPat [0:10] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    int cnt;
    int lowCnt;
    int hold;
    int gap;
    logic bit1;

    $display("[TB] reset and idle");
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'b0, ready}, 32'd1);
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_ready", {31'b0, ready}, 32'd1);
      checkOutput("idle_tx", {31'b0, tx}, 32'd1);
    end

    $display("[TB] single frame 0x89");
    pulseSend(8'h89);
    capture(FB * N + 4);
    for (int k = 0; k < FB; k++) begin
      checkOutput($sformatf("f89_bit%0d_first", k), {31'b0, rec[k * N]}, expPat[k]);
      checkOutput($sformatf("f89_bit%0d_mid", k), {31'b0, rec[k * N + N / 2]}, expPat[k]);
      checkOutput($sformatf("f89_bit%0d_last", k), {31'b0, rec[k * N + N - 1]}, expPat[k]);
      checkOutput($sformatf("model_bit%0d", k), {31'b0, mRec[k * N + N / 2]}, expPat[k]);
    end
    cnt = 0;
    for (int i = 0; i < FB * N + 4; i++) if (!rdy[i]) cnt++;
    checkOutput("f89_ready_low_cycles", cnt, FB * N);
    checkOutput("f89_ready_last_low", {31'b0, rdy[FB * N - 1]}, 32'd0);
    checkOutput("f89_ready_back", {31'b0, rdy[FB * N]}, 32'd1);

    $display("[TB] held send, data changed mid-frame");
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'hA3);
    capture(2 * FB * N + 4);
    applyStimulus(1'b0, 8'h00);
    checkOutput("held_first_byte", decodeByte(0), 32'h55);
    checkOutput("held_second_byte", decodeByte(FB * N + 1), 32'hA3);
    checkOutput("held_gap_before", {31'b0, rdy[FB * N - 1]}, 32'd0);
    checkOutput("held_gap_ready", {31'b0, rdy[FB * N]}, 32'd1);
    checkOutput("held_gap_after", {31'b0, rdy[FB * N + 1]}, 32'd0);
    checkOutput("held_second_start", {31'b0, rec[FB * N + 1]}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 2 * FB * N + 1; i++) if (rdy[i]) cnt++;
    checkOutput("held_ready_high_cycles", cnt, 32'd1);
    waitIdle(200);

    $display("[TB] reset during data bit 3");
    pulseSend(8'hFF);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", {31'b0, tx}, 32'd1);
    checkOutput("abort_ready", {31'b0, ready}, 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_still_idle", {31'b0, tx}, 32'd1);
    pulseSend(8'h00);
    capture(FB * N + 4);
    checkOutput("post_abort_byte", decodeByte(0), 32'h00);
    checkOutput("post_abort_start", {31'b0, rec[N / 2]}, 32'd0);
    checkOutput("post_abort_stop", {31'b0, rec[(FB - 1) * N + N / 2]}, 32'd1);
    checkOutput("post_abort_ready_back", {31'b0, rdy[FB * N]}, 32'd1);
    checkOutput("post_abort_ready_low", {31'b0, rdy[FB * N - 1]}, 32'd0);

    $display("[TB] reset and send on the same edge");
    @(negedge clk);
    reset = 1'b1;
    send  = 1'b1;
    data  = 8'h5A;
    @(negedge clk);
    reset = 1'b0;
    send  = 1'b0;
    checkOutput("rst_prio_ready", {31'b0, ready}, 32'd1);
    checkOutput("rst_prio_tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    checkOutput("rst_prio_not_accepted", {31'b0, ready}, 32'd1);

    $display("[TB] randomized traffic");
    for (int f = 0; f < 40; f++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
      send = 1'b1;
      data = 8'($urandom);
      hold = $urandom_range(1, FB * N + 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        data  = 8'($urandom);
        reset = ($urandom_range(0, 59) == 0);
      end
      send  = 1'b0;
      reset = 1'b0;
    end
    @(negedge clk);
    waitIdle(200);

    $display("[TB] full-rate divider");
    @(negedge clk);
    sendSlow = 1'b1;
    dataSlow = 8'h0A;
    @(negedge clk);
    sendSlow = 1'b0;
    lowCnt = 0;
    cnt = 0;
    bit1 = 1'b0;
    for (int i = 0; i < FB * NS + 10; i++) begin
      if (i < NS && !txSlow) lowCnt++;
      if (i == 2 * NS + NS / 2) bit1 = txSlow;
      if (!readySlow) cnt++;
      if (i == FB * NS) checkOutput("slow_ready_back", {31'b0, readySlow}, 32'd1);
      @(negedge clk);
    end
    checkOutput("slow_start_low_cycles", lowCnt, NS);
    checkOutput("slow_bit1", {31'b0, bit1}, 32'd1);
    checkOutput("slow_frame_cycles", cnt, FB * NS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
